// File: rtl/status_pkg.sv
// Shared encodings for the condition-flag unit: flag bit positions, condition
// codes and the branch-condition decoder used by the eval path.
package status_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [3:0] {
        CC_AL = 4'd0,
        CC_EQ = 4'd1,
        CC_NE = 4'd2,
        CC_CS = 4'd3,
        CC_CC = 4'd4,
        CC_MI = 4'd5,
        CC_PL = 4'd6,
        CC_VS = 4'd7,
        CC_VC = 4'd8,
        CC_HI = 4'd9,
        CC_LS = 4'd10,
        CC_GE = 4'd11,
        CC_LT = 4'd12,
        CC_GT = 4'd13,
        CC_LE = 4'd14,
        CC_NV = 4'd15
    } cc_e;

    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic z;
        logic n;
        logic c;
        logic v;
        logic r;
        z = f[FLAG_Z];
        n = f[FLAG_N];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cc_e'(cc))
            CC_AL:   r = 1'b1;
            CC_EQ:   r = z;
            CC_NE:   r = ~z;
            CC_CS:   r = c;
            CC_CC:   r = ~c;
            CC_MI:   r = n;
            CC_PL:   r = ~n;
            CC_VS:   r = v;
            CC_VC:   r = ~v;
            CC_HI:   r = c & ~z;
            CC_LS:   r = ~c | z;
            CC_GE:   r = (n == v);
            CC_LT:   r = (n != v);
            CC_GT:   r = ~z & (n == v);
            CC_LE:   r = z | (n != v);
            CC_NV:   r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/status_shadow_stack.sv
// LIFO of saved flag sets for interrupt entry/return. Illegal requests
// (push full, pop empty, push with pop) leave the stack alone and raise a sticky error.
module status_shadow_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clr_err,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         pop_ok,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [W-1:0]     mem_r [DEPTH];
    logic             empty_r;
    logic             full_r;
    logic             err_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             err_set_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;

    // Accept/reject decision and next occupancy.
    always_comb begin
        push_ok_s    = push & ~pop & ~full_r;
        pop_ok_s     = pop & ~push & ~empty_r;
        err_set_s    = (push & pop) | (push & ~pop & full_r) | (pop & ~push & empty_r);
        wr_idx_s     = IDX_W'(count_r);
        rd_idx_s     = IDX_W'(count_r - CNT_ONE);
        count_next_s = count_r;
        if (push_ok_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_ok_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Occupancy, status flags and the sticky error bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            empty_r <= (count_next_s == {CNT_W{1'b0}});
            full_r  <= (count_next_s == CNT_FULL);
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (clr_err) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Entry storage; cleared on reset so no stale flag set can be restored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_idx_s] <= din;
        end else begin
            mem_r[wr_idx_s] <= mem_r[wr_idx_s];
        end
    end

    assign dout   = mem_r[rd_idx_s];
    assign pop_ok = pop_ok_s;
    assign empty  = empty_r;
    assign full   = full_r;
    assign err    = err_r;

endmodule

// File: rtl/status_flag_unit.sv
// Condition-flag unit: derives and stores Z/N/C/V, tracks sticky overflow,
// saves/restores flag sets via the shadow stack and answers branch queries.
module status_flag_unit
    import status_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int SHADOW_DEPTH = 4,
    parameter int FWD          = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] result,
    input  logic              carry_out,
    input  logic              carry_msb_in,
    input  logic              flag_we,
    input  logic [3:0]        flag_mask,
    input  logic              eval,
    input  logic [3:0]        cc,
    input  logic              push,
    input  logic              pop,
    input  logic              clear_sticky,
    output logic [3:0]        flags,
    output logic              sticky_v,
    output logic              status,
    output logic              status_valid,
    output logic              shadow_empty,
    output logic              shadow_full,
    output logic              shadow_err
);

    logic [3:0] flags_r;
    logic       sticky_r;
    logic       status_r;
    logic       valid_r;
    logic [3:0] next_flags_s;
    logic [3:0] wmask_s;
    logic [3:0] commit_s;
    logic [3:0] eval_flags_s;
    logic [3:0] pop_data_s;
    logic       pop_ok_s;
    logic       sv_set_s;

    status_shadow_stack #(
        .DEPTH (SHADOW_DEPTH),
        .W     (4)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .clr_err (clear_sticky),
        .din     (flags_r),
        .dout    (pop_data_s),
        .pop_ok  (pop_ok_s),
        .empty   (shadow_empty),
        .full    (shadow_full),
        .err     (shadow_err)
    );

    // Candidate flags, masked merge, pop override and the eval source select.
    always_comb begin
        next_flags_s         = 4'b0000;
        next_flags_s[FLAG_Z] = (result == {DATA_W{1'b0}});
        next_flags_s[FLAG_N] = result[DATA_W-1];
        next_flags_s[FLAG_C] = carry_out;
        next_flags_s[FLAG_V] = carry_out ^ carry_msb_in;
        wmask_s              = flag_mask & {4{flag_we}};
        if (pop_ok_s) begin
            commit_s = pop_data_s;
        end else begin
            commit_s = (flags_r & ~wmask_s) | (next_flags_s & wmask_s);
        end
        sv_set_s = wmask_s[FLAG_V] & next_flags_s[FLAG_V] & ~pop_ok_s;
        if (FWD != 0) begin
            eval_flags_s = commit_s;
        end else begin
            eval_flags_s = flags_r;
        end
    end

    // Flag register, sticky overflow and the registered branch status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r  <= 4'b0000;
            sticky_r <= 1'b0;
            status_r <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            flags_r <= commit_s;
            valid_r <= eval;
            if (sv_set_s) begin
                sticky_r <= 1'b1;
            end else if (clear_sticky) begin
                sticky_r <= 1'b0;
            end else begin
                sticky_r <= sticky_r;
            end
            if (eval) begin
                status_r <= cond_eval(cc, eval_flags_s);
            end else begin
                status_r <= status_r;
            end
        end
    end

    assign flags        = flags_r;
    assign sticky_v     = sticky_r;
    assign status       = status_r;
    assign status_valid = valid_r;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: one FWD=0 and one FWD=1 instance share
// all stimulus; expected values are hand-computed constants.
module tb_status_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] result;
    logic        carry_out;
    logic        carry_msb_in;
    logic        flag_we;
    logic [3:0]  flag_mask;
    logic        eval;
    logic [3:0]  cc;
    logic        push;
    logic        pop;
    logic        clear_sticky;

    logic [3:0]  flags_a, flags_b;
    logic        sticky_a, sticky_b;
    logic        status_a, status_b;
    logic        valid_a, valid_b;
    logic        empty_a, empty_b;
    logic        full_a, full_b;
    logic        err_a, err_b;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [3:0] nv [5];

    status_flag_unit #(.DATA_W(16), .SHADOW_DEPTH(4), .FWD(0)) dut (
        .clk(clk), .rst_n(rst_n), .result(result), .carry_out(carry_out),
        .carry_msb_in(carry_msb_in), .flag_we(flag_we), .flag_mask(flag_mask),
        .eval(eval), .cc(cc), .push(push), .pop(pop), .clear_sticky(clear_sticky),
        .flags(flags_a), .sticky_v(sticky_a), .status(status_a), .status_valid(valid_a),
        .shadow_empty(empty_a), .shadow_full(full_a), .shadow_err(err_a)
    );

    status_flag_unit #(.DATA_W(16), .SHADOW_DEPTH(4), .FWD(1)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .result(result), .carry_out(carry_out),
        .carry_msb_in(carry_msb_in), .flag_we(flag_we), .flag_mask(flag_mask),
        .eval(eval), .cc(cc), .push(push), .pop(pop), .clear_sticky(clear_sticky),
        .flags(flags_b), .sticky_v(sticky_b), .status(status_b), .status_valid(valid_b),
        .shadow_empty(empty_b), .shadow_full(full_b), .shadow_err(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        result       = 16'h0000;
        carry_out    = 1'b0;
        carry_msb_in = 1'b0;
        flag_we      = 1'b0;
        flag_mask    = 4'b0000;
        eval         = 1'b0;
        cc           = 4'd0;
        push         = 1'b0;
        pop          = 1'b0;
        clear_sticky = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive ALU inputs so that the derived {V,C,N,Z} equals f (N and Z never both set).
    task automatic set_nf(input logic [3:0] f);
        result       = f[0] ? 16'h0000 : (f[1] ? 16'h8000 : 16'h0001);
        carry_out    = f[2];
        carry_msb_in = f[2] ^ f[3];
        flag_we      = 1'b1;
        flag_mask    = 4'b1111;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_flags"}, flags_a, 4'b0000);
        chk({tag, "_sticky"}, {3'b000, sticky_a}, 4'd0);
        chk({tag, "_status"}, {3'b000, status_a}, 4'd0);
        chk({tag, "_valid"}, {3'b000, valid_a}, 4'd0);
        chk({tag, "_empty"}, {3'b000, empty_a}, 4'd1);
        chk({tag, "_full"}, {3'b000, full_a}, 4'd0);
        chk({tag, "_err"}, {3'b000, err_a}, 4'd0);
        chk({tag, "_fwd_flags"}, flags_b, 4'b0000);
        chk({tag, "_fwd_valid"}, {3'b000, valid_b}, 4'd0);
        chk({tag, "_fwd_empty"}, {3'b000, empty_b}, 4'd1);
    endtask

    initial begin
        nv[0] = 4'b1010;
        nv[1] = 4'b0010;
        nv[2] = 4'b1001;
        nv[3] = 4'b0100;
        nv[4] = 4'b1000;
        idle();
        rst_n = 1'b0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // AL / NV on reset flags, back-to-back pulses
        eval = 1'b1; cc = 4'd0;
        step();
        chk("al_status", {3'b000, status_a}, 4'd1);
        chk("al_valid", {3'b000, valid_a}, 4'd1);
        cc = 4'd15;
        step();
        chk("nv_status", {3'b000, status_a}, 4'd0);
        chk("nv_valid", {3'b000, valid_a}, 4'd1);
        idle();
        step();
        chk("valid_drop", {3'b000, valid_a}, 4'd0);
        chk("status_hold", {3'b000, status_a}, 4'd0);
        chk("flags_zero", flags_a, 4'b0000);

        // full write: Z=1 N=0 C=1 V=1
        result = 16'h0000; carry_out = 1'b1; carry_msb_in = 1'b0;
        flag_we = 1'b1; flag_mask = 4'b1111;
        step();
        chk("wr_all_flags", flags_a, 4'b1101);
        chk("wr_all_sticky", {3'b000, sticky_a}, 4'd1);
        idle(); eval = 1'b1; cc = 4'd11;
        step();
        chk("ge_status", {3'b000, status_a}, 4'd0);
        cc = 4'd12;
        step();
        chk("lt_status", {3'b000, status_a}, 4'd1);
        cc = 4'd9;
        step();
        chk("hi_status", {3'b000, status_a}, 4'd0);

        // masked write: only Z
        idle(); result = 16'h8000; flag_we = 1'b1; flag_mask = 4'b0001;
        step();
        chk("mask_z_only", flags_a, 4'b1100);

        // same-cycle eval: FWD=0 sees old Z, FWD=1 sees new Z
        idle(); result = 16'h0000; flag_we = 1'b1; flag_mask = 4'b0001;
        eval = 1'b1; cc = 4'd1;
        step();
        chk("eq_nofwd", {3'b000, status_a}, 4'd0);
        chk("eq_fwd", {3'b000, status_b}, 4'd1);
        chk("eq_flags", flags_a, 4'b1101);
        chk("eq_fwd_flags", flags_b, 4'b1101);

        // sticky clear, then set-wins-over-clear
        idle(); clear_sticky = 1'b1;
        step();
        chk("sv_clear", {3'b000, sticky_a}, 4'd0);
        idle(); carry_out = 1'b1; flag_we = 1'b1; flag_mask = 4'b1000; clear_sticky = 1'b1;
        step();
        chk("sv_set_wins", {3'b000, sticky_a}, 4'd1);
        chk("sv_set_flags", flags_a, 4'b1101);
        idle(); clear_sticky = 1'b1;
        step();
        chk("sv_clear2", {3'b000, sticky_a}, 4'd0);

        // push 0101 while writing 1010, then pop overriding a write
        idle(); set_nf(4'b0101);
        step();
        chk("pre_push_flags", flags_a, 4'b0101);
        idle(); set_nf(4'b1010); push = 1'b1;
        step();
        chk("push_we_flags", flags_a, 4'b1010);
        chk("push_not_empty", {3'b000, empty_a}, 4'd0);
        chk("push_sticky", {3'b000, sticky_a}, 4'd1);
        idle(); set_nf(4'b0001); pop = 1'b1; eval = 1'b1; cc = 4'd1;
        step();
        chk("pop_flags", flags_a, 4'b0101);
        chk("pop_fwd_flags", flags_b, 4'b0101);
        chk("pop_empty", {3'b000, empty_a}, 4'd1);
        chk("pop_eq_nofwd", {3'b000, status_a}, 4'd0);
        chk("pop_eq_fwd", {3'b000, status_b}, 4'd1);
        chk("pop_no_err", {3'b000, err_a}, 4'd0);

        // fill: stack gets 0101,1010,0010,1001
        for (int i = 0; i < 4; i++) begin
            idle(); set_nf(nv[i]); push = 1'b1;
            step();
        end
        chk("fill_full", {3'b000, full_a}, 4'd1);
        chk("fill_err", {3'b000, err_a}, 4'd0);
        chk("fill_flags", flags_a, 4'b0100);
        idle(); set_nf(nv[4]); push = 1'b1;
        step();
        chk("over_full", {3'b000, full_a}, 4'd1);
        chk("over_err", {3'b000, err_a}, 4'd1);
        chk("over_flags", flags_a, 4'b1000);
        idle(); clear_sticky = 1'b1;
        step();
        chk("err_clear", {3'b000, err_a}, 4'd0);

        idle(); pop = 1'b1;
        step();
        chk("pop1", flags_a, 4'b1001);
        chk("pop1_not_full", {3'b000, full_a}, 4'd0);
        step();
        chk("pop2", flags_a, 4'b0010);
        step();
        chk("pop3", flags_a, 4'b1010);
        step();
        chk("pop4", flags_a, 4'b0101);
        chk("pop4_empty", {3'b000, empty_a}, 4'd1);
        step();
        chk("underflow_err", {3'b000, err_a}, 4'd1);
        chk("underflow_flags", flags_a, 4'b0101);

        // push+pop together: error, no stack change, write still applies
        idle(); clear_sticky = 1'b1;
        step();
        idle(); set_nf(4'b0010); push = 1'b1; pop = 1'b1;
        step();
        chk("pp_err", {3'b000, err_a}, 4'd1);
        chk("pp_empty", {3'b000, empty_a}, 4'd1);
        chk("pp_flags", flags_a, 4'b0010);

        // reset mid-stack with eval pending
        idle(); push = 1'b1;
        step();
        step();
        chk("pre_rst_not_empty", {3'b000, empty_a}, 4'd0);
        idle(); eval = 1'b1; cc = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        step();
        chk("midrst_valid_edge", {3'b000, valid_a}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); pop = 1'b1;
        step();
        chk("post_rst_pop_err", {3'b000, err_a}, 4'd1);
        chk("post_rst_flags", flags_a, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Parametrised condition-flag unit for the multi-cycle CPU: derives Z/N/C/V from the ALU result, stores them under per-flag write masks, and answers branch-condition queries from the control FSM with a registered status bit. It adds a sticky-overflow flag and a LIFO shadow stack of flag sets for interrupt entry/return. It sits between the ALU outputs and the control unit's branch state.

## Interface
- DATA_W, 16, ALU result width (≥2)
- SHADOW_DEPTH, 4, flag-set entries in shadow stack (≥1)
- FWD, 0, 1 = eval sees flags written in the same cycle; 0 = eval sees pre-update flags
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- result  in  DATA_W  ALU result
- carry_out  in  1  carry out of MSB
- carry_msb_in  in  1  carry into MSB
- flag_we  in  1  commit flags this cycle
- flag_mask  in  4  per-flag write enable {V,C,N,Z}, qualified by flag_we
- eval  in  1  condition query strobe
- cc  in  4  condition code for eval
- push  in  1  save current flags to shadow stack
- pop  in  1  restore flags from shadow stack
- clear_sticky  in  1  clear SV and shadow_err
- flags  out  4  current {V,C,N,Z}
- sticky_v  out  1  SV, set by any committed V=1
- status  out  1  condition result
- status_valid  out  1  one-cycle pulse qualifying status
- shadow_empty  out  1  stack holds 0 entries
- shadow_full  out  1  stack holds SHADOW_DEPTH entries
- shadow_err  out  1  sticky push-full / pop-empty / push+pop error

## Operation
- Next-flag values: Z = (result == 0), N = result[DATA_W-1], C = carry_out, V = carry_out ^ carry_msb_in.
- flag_we=1: each flag with mask bit set takes its next value; masked-off flags hold.
- SV: set when V is written with 1; clear_sticky clears it; set wins over simultaneous clear.
- Condition codes: 0 AL=1, 1 EQ=Z, 2 NE=!Z, 3 CS=C, 4 CC=!C, 5 MI=N, 6 PL=!N, 7 VS=V, 8 VC=!V, 9 HI=C&!Z, 10 LS=!C|Z, 11 GE=(N==V), 12 LT=(N!=V), 13 GT=!Z&(N==V), 14 LE=Z|(N!=V), 15 NV=0.
- eval: status <= decode(cc, F); F = registered flags when FWD=0, or the flag value being committed this cycle (masked merge) when FWD=1. status holds until next eval.
- push (alone): stack[top] <= current flags (pre-update), count+1; a simultaneous flag_we still updates flags.
- pop (alone): flags <= stack[top-1], count-1; overrides simultaneous flag_we completely; FWD eval in that cycle uses the popped value.
- push when full or pop when empty: ignored, shadow_err <= 1.
- push and pop together: no stack change, no flag restore, shadow_err <= 1; flag_we still applies.
- shadow_err cleared only by clear_sticky or reset; error set wins over clear.

## Timing
- Reset (async assert, sync to clk on release): flags=0, sticky_v=0, status=0, status_valid=0, stack count=0 (shadow_empty=1, shadow_full=0), shadow_err=0. Reset mid-operation discards stack contents.
- flag_we at edge t → flags visible after t (1-cycle).
- eval at edge t → status, status_valid=1 during cycle t+1; status_valid low otherwise. Back-to-back evals give back-to-back pulses.
- push/pop at edge t → shadow_empty/full reflect new count after t; popped flags visible after t.
- No combinational path from inputs to any output.

## Structure
- Package status_pkg: cc encodings (CC_AL…CC_NV), flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3), and a cond_eval function (cc, flags) → bit.
- Sub-module status_shadow_stack (#SHADOW_DEPTH, 4-bit entries): push/pop/count/full/empty/err; top module handles flag logic, eval register, FWD mux.

## Test plan
- Reset, then eval cc=0 → status=1, valid pulse 1 cycle later; eval cc=15 → status=0; flags=0000.
- result=0x0000, carry_out=1, carry_msb_in=0, mask=1111, we → flags {V,C,N,Z}=1101, sticky_v=1; eval GE → 0, LT → 1.
- mask=0001 with result=0x8000 → only Z written (0), N unchanged; FWD=1 eval EQ same cycle as we(result=0) → status=1; FWD=0 → old Z.
- Push flags 0101, we new flags 1010 same cycle, pop next cycle → flags return to 0101, shadow_empty=1.
- SHADOW_DEPTH=4: 5 pushes → shadow_full=1, shadow_err=1, stack unchanged; clear_sticky → err=0; pop on empty → err=1.
- Assert rst_n low mid-stack (count=2) with eval pending → all outputs at reset values, status_valid=0, shadow_empty=1.
